// File: rtl/dma_timing_priority_ctrl_if.sv
// Bus-side handshake and strobe bundle of the DMA timing/priority controller.
interface dma_timing_priority_ctrl_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0] DREQ;
  logic                HLDA;
  logic                EOP_N;
  logic                HRQ;
  logic [CHANNELS-1:0] DACK;
  logic                AEN;
  logic                ADSTB;
  logic                MEMR_N;
  logic                MEMW_N;
  logic                IOR_N;
  logic                IOW_N;

  // Controller side: receives requests/acknowledge, drives hold request and strobes.
  modport master (
    input  DREQ, HLDA, EOP_N,
    output HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N
  );

  // System side: raises requests and hold acknowledge, observes the bus cycle.
  modport slave (
    output DREQ, HLDA, EOP_N,
    input  HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N
  );
endinterface

// File: rtl/dma_timing_priority_ctrl.sv
// Per-transfer sequencer (SI, S0..S4) and channel arbiter of the 4-channel DMA.
// All outputs are registered Moore decodes of the state being entered.
module dma_timing_priority_ctrl #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned ADDRESSWIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  dma_timing_priority_ctrl_if.master bus,
  input  logic [CHANNELS-1:0]     chMask,
  input  logic                    ctrlDisable,
  input  logic                    rotPriority,
  input  logic [CHANNELS-1:0]     demandMode,
  input  logic [2*CHANNELS-1:0]   xferType,
  input  logic                    tcReached,
  output logic                    programCondition,
  output logic                    loadAddr,
  output logic                    incrTemporaryAddressReg,
  output logic                    decrTemporaryWordCountReg,
  output logic                    updateCurrentAddressReg,
  output logic                    updateCurrentWordCountReg,
  output logic                    intEOP
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Address width only sizes the datapath; reject a degenerate setting early.
  if (ADDRESSWIDTH == 0) begin : gAddrWidthCheck
    $error("ADDRESSWIDTH must be nonzero");
  end

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} stateType;

  stateType            state, stateNext;
  logic [CH_W-1:0]     activeCh, chNext;
  logic [CH_W-1:0]     priPtr, ptrNext;
  logic                eopSeen, eopSeenNext;

  logic [CHANNELS-1:0] eligible;
  logic [CH_W-1:0]     scanBase;
  logic [CH_W-1:0]     winner;
  logic                found;
  int unsigned         idx;

  logic [1:0]          xtNext;
  logic                readActive, writeActive;
  logic                hrqD, aenD, adstbD, pulseD, intEopD;
  logic [CHANNELS-1:0] dackD;

  // Pick the first eligible request scanning upward from the priority pointer.
  always_comb begin
    eligible = bus.DREQ & ~chMask;
    scanBase = rotPriority ? priPtr : '0;
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = (32'(scanBase) + i) % CHANNELS;
      if (!found && eligible[CH_W'(idx)]) begin
        found  = 1'b1;
        winner = CH_W'(idx);
      end
    end
  end

  // Next state, channel/pointer bookkeeping and decode of the state being entered.
  always_comb begin
    stateNext   = state;
    chNext      = activeCh;
    ptrNext     = priPtr;
    eopSeenNext = 1'b0;

    case (state)
      SI: begin
        if (!ctrlDisable && found) begin
          stateNext = S0;
          chNext    = winner;
        end
      end
      S0: begin
        if (bus.HLDA) begin
          stateNext = S1;
        end else if (!bus.DREQ[activeCh]) begin
          stateNext = SI;
        end
      end
      S1: stateNext = bus.HLDA ? S2 : SI;
      S2: begin
        eopSeenNext = eopSeen | ~bus.EOP_N;
        stateNext   = bus.HLDA ? S3 : SI;
      end
      S3: begin
        eopSeenNext = eopSeen | ~bus.EOP_N;
        stateNext   = bus.HLDA ? S4 : SI;
      end
      S4: begin
        ptrNext = rotPriority ? CH_W'((32'(activeCh) + 32'd1) % CHANNELS) : '0;
        // intEOP holds the terminal decision made on entry to S4.
        if (demandMode[activeCh] && bus.DREQ[activeCh] && !chMask[activeCh] &&
            !intEOP && bus.HLDA) begin
          stateNext = S1;
        end else begin
          stateNext = SI;
        end
      end
      default: stateNext = SI;
    endcase

    xtNext      = xferType[{chNext, 1'b0} +: 2];
    readActive  = (stateNext == S2) || (stateNext == S3);
    writeActive = (stateNext == S3);
    hrqD        = (stateNext != SI);
    aenD        = (stateNext inside {S1, S2, S3, S4});
    adstbD      = (stateNext == S1);
    pulseD      = (stateNext == S4);
    intEopD     = (stateNext == S4) && (tcReached || eopSeenNext);
    dackD       = '0;
    if (aenD) begin
      dackD[chNext] = 1'b1;
    end
  end

  // State, bookkeeping and registered output update.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state                     <= SI;
      activeCh                  <= '0;
      priPtr                    <= '0;
      eopSeen                   <= 1'b0;
      bus.HRQ                   <= 1'b0;
      bus.DACK                  <= '0;
      bus.AEN                   <= 1'b0;
      bus.ADSTB                 <= 1'b0;
      bus.MEMR_N                <= 1'b1;
      bus.MEMW_N                <= 1'b1;
      bus.IOR_N                 <= 1'b1;
      bus.IOW_N                 <= 1'b1;
      programCondition          <= 1'b1;
      loadAddr                  <= 1'b0;
      incrTemporaryAddressReg   <= 1'b0;
      decrTemporaryWordCountReg <= 1'b0;
      updateCurrentAddressReg   <= 1'b0;
      updateCurrentWordCountReg <= 1'b0;
      intEOP                    <= 1'b0;
    end else begin
      state                     <= stateNext;
      activeCh                  <= chNext;
      priPtr                    <= ptrNext;
      eopSeen                   <= eopSeenNext;
      bus.HRQ                   <= hrqD;
      bus.DACK                  <= dackD;
      bus.AEN                   <= aenD;
      bus.ADSTB                 <= adstbD;
      bus.MEMR_N                <= ~(readActive && (xtNext == 2'b10));
      bus.IOR_N                 <= ~(readActive && (xtNext == 2'b01));
      bus.MEMW_N                <= ~(writeActive && (xtNext == 2'b01));
      bus.IOW_N                 <= ~(writeActive && (xtNext == 2'b10));
      programCondition          <= (stateNext == SI);
      loadAddr                  <= adstbD;
      incrTemporaryAddressReg   <= pulseD;
      decrTemporaryWordCountReg <= pulseD;
      updateCurrentAddressReg   <= pulseD;
      updateCurrentWordCountReg <= pulseD;
      intEOP                    <= intEopD;
    end
  end

endmodule

// File: tb/tb_dma_timing_priority_ctrl.sv
// Bench for dma_timing_priority_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a transfer-level model.
module tb_dma_timing_priority_ctrl;

  localparam int unsigned CH = 4;

  logic CLK = 1'b0;
  logic RESET_N;
  logic [CH-1:0]   chMask;
  logic            ctrlDisable;
  logic            rotPriority;
  logic [CH-1:0]   demandMode;
  logic [2*CH-1:0] xferType;
  logic            tcReached;
  logic programCondition, loadAddr, incrA, decrW, updA, updW, intEOP;

  dma_timing_priority_ctrl_if #(.CHANNELS(CH)) bus ();

  dma_timing_priority_ctrl #(.CHANNELS(CH), .ADDRESSWIDTH(16)) dut (
    .CLK                       (CLK),
    .RESET_N                   (RESET_N),
    .bus                       (bus),
    .chMask                    (chMask),
    .ctrlDisable               (ctrlDisable),
    .rotPriority               (rotPriority),
    .demandMode                (demandMode),
    .xferType                  (xferType),
    .tcReached                 (tcReached),
    .programCondition          (programCondition),
    .loadAddr                  (loadAddr),
    .incrTemporaryAddressReg   (incrA),
    .decrTemporaryWordCountReg (decrW),
    .updateCurrentAddressReg   (updA),
    .updateCurrentWordCountReg (updW),
    .intEOP                    (intEOP)
  );

  always #5 CLK = ~CLK;

  int testsRun = 0;
  int testsFailed = 0;
  int grantQ[$];

  // Output vector: {HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, progCond, loadAddr, 4 pulses, intEOP}
  function automatic logic [17:0] ex(input logic hrq, input logic [3:0] dack, input logic aen,
                                     input logic adstb, input logic [3:0] strb, input logic pc,
                                     input logic ld, input logic pulse, input logic ieop);
    return {hrq, dack, aen, adstb, strb, pc, ld, {4{pulse}}, ieop};
  endfunction

  function automatic logic [17:0] actual();
    return {bus.HRQ, bus.DACK, bus.AEN, bus.ADSTB, bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N,
            programCondition, loadAddr, incrA, decrW, updA, updW, intEOP};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic doReset();
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic waitAdstb(input string name);
    int c;
    c = 0;
    while (!bus.ADSTB && c < 20) begin
      tick();
      c++;
    end
    if (!bus.ADSTB) begin
      testsRun++;
      testsFailed++;
      $display("FAIL %s: no address strobe within 20 cycles", name);
    end
  endtask

  // Record the channel of each new acknowledge (DACK rising from zero).
  task automatic collectGrants(input int n, input int budget);
    logic [3:0] prev;
    prev = '0;
    grantQ.delete();
    for (int c = 0; c < budget && grantQ.size() < n; c++) begin
      tick();
      if (bus.DACK != 0 && prev == 0) begin
        for (int b = 0; b < 4; b++) if (bus.DACK[b]) grantQ.push_back(b);
      end
      prev = bus.DACK;
    end
    if (grantQ.size() < n) begin
      testsRun++;
      testsFailed++;
      $display("FAIL grant timeout: got %0d grants expected %0d", grantQ.size(), n);
    end
  endtask

  // Transfer-level reference: phase 0=idle, 1=hold wait, 2..5 = bus cycle steps S1..S4.
  int mPhase, mCh, mPtr;
  bit mEop, mTerm;

  task automatic modelStep();
    logic [3:0] elig;
    int base;
    elig = bus.DREQ & ~chMask;
    case (mPhase)
      0: if (!ctrlDisable && elig != 0) begin
           base = rotPriority ? mPtr : 0;
           for (int k = 0; k < 4; k++) begin
             if (elig[(base + k) % 4]) begin
               mCh = (base + k) % 4;
               break;
             end
           end
           mPhase = 1;
         end
      1: if (bus.HLDA) mPhase = 2; else if (!bus.DREQ[mCh]) mPhase = 0;
      2, 3, 4: if (!bus.HLDA) begin
                 mPhase = 0;
                 mEop = 0;
               end else begin
                 if (mPhase >= 3 && !bus.EOP_N) mEop = 1;
                 if (mPhase == 4) mTerm = tcReached | mEop;
                 mPhase++;
               end
      default: begin
        mPtr = rotPriority ? (mCh + 1) % 4 : 0;
        mPhase = (demandMode[mCh] && bus.DREQ[mCh] && !chMask[mCh] && !mTerm && bus.HLDA) ? 2 : 0;
        mEop = 0;
      end
    endcase
  endtask

  function automatic logic [17:0] modelOut();
    logic [1:0] xt;
    logic [3:0] strb;
    logic [3:0] dack;
    bit rd, wr;
    xt = 2'(xferType >> (2 * mCh));
    rd = (mPhase == 3 || mPhase == 4);
    wr = (mPhase == 4);
    strb = {!(rd && xt == 2'b10), !(wr && xt == 2'b01), !(rd && xt == 2'b01), !(wr && xt == 2'b10)};
    dack = (mPhase >= 2) ? 4'(1 << mCh) : 4'b0;
    return ex(mPhase != 0, dack, mPhase >= 2, mPhase == 2, strb, mPhase == 0, mPhase == 2,
              mPhase == 5, mPhase == 5 && mTerm);
  endfunction

  typedef struct {
    logic [3:0]  dreq;
    logic        hlda;
    logic        tc;
    logic [17:0] expv;
  } vecType;

  vecType vecs[14];
  int expRot[5];
  int expMask[4];
  int s1Cnt, pulseCnt, eopAt;
  bit done, hrqGap, dackGap, pulseSeen;

  initial begin
    RESET_N = 1'b0;
    chMask = '0; ctrlDisable = 1'b0; rotPriority = 1'b0; demandMode = '0;
    xferType = 8'b00_10_01_00; tcReached = 1'b0;
    bus.DREQ = '0; bus.HLDA = 1'b0; bus.EOP_N = 1'b1;

    // Fixed priority: ch1 (write) then ch2 (read, last transfer).
    vecs[0]  = '{4'b0110, 1'b0, 1'b0, ex(1, 4'b0000, 0, 0, 4'b1111, 0, 0, 0, 0)};
    vecs[1]  = '{4'b0110, 1'b0, 1'b0, ex(1, 4'b0000, 0, 0, 4'b1111, 0, 0, 0, 0)};
    vecs[2]  = '{4'b0110, 1'b1, 1'b0, ex(1, 4'b0010, 1, 1, 4'b1111, 0, 1, 0, 0)};
    vecs[3]  = '{4'b0110, 1'b1, 1'b0, ex(1, 4'b0010, 1, 0, 4'b1101, 0, 0, 0, 0)};
    vecs[4]  = '{4'b0110, 1'b1, 1'b0, ex(1, 4'b0010, 1, 0, 4'b1001, 0, 0, 0, 0)};
    vecs[5]  = '{4'b0110, 1'b1, 1'b0, ex(1, 4'b0010, 1, 0, 4'b1111, 0, 0, 1, 0)};
    vecs[6]  = '{4'b0100, 1'b1, 1'b0, ex(0, 4'b0000, 0, 0, 4'b1111, 1, 0, 0, 0)};
    vecs[7]  = '{4'b0100, 1'b1, 1'b0, ex(1, 4'b0000, 0, 0, 4'b1111, 0, 0, 0, 0)};
    vecs[8]  = '{4'b0100, 1'b1, 1'b0, ex(1, 4'b0100, 1, 1, 4'b1111, 0, 1, 0, 0)};
    vecs[9]  = '{4'b0100, 1'b1, 1'b0, ex(1, 4'b0100, 1, 0, 4'b0111, 0, 0, 0, 0)};
    vecs[10] = '{4'b0100, 1'b1, 1'b0, ex(1, 4'b0100, 1, 0, 4'b0110, 0, 0, 0, 0)};
    vecs[11] = '{4'b0100, 1'b1, 1'b1, ex(1, 4'b0100, 1, 0, 4'b1111, 0, 0, 1, 1)};
    vecs[12] = '{4'b0000, 1'b1, 1'b1, ex(0, 4'b0000, 0, 0, 4'b1111, 1, 0, 0, 0)};
    vecs[13] = '{4'b0000, 1'b0, 1'b0, ex(0, 4'b0000, 0, 0, 4'b1111, 1, 0, 0, 0)};
    expRot  = '{0, 1, 2, 3, 0};
    expMask = '{0, 1, 3, 0};

    // Reset asserted in the middle of S2.
    doReset();
    check("reset idle", 32'(actual()), 32'(ex(0, 4'b0000, 0, 0, 4'b1111, 1, 0, 0, 0)));
    xferType = 8'b00_00_00_01;
    bus.DREQ = 4'b0001; bus.HLDA = 1'b1;
    tick(); tick(); tick();
    check("pre-reset S2", 32'(actual()), 32'(ex(1, 4'b0001, 1, 0, 4'b1101, 0, 0, 0, 0)));
    RESET_N = 1'b0;
    tick();
    check("reset from S2", 32'(actual()), 32'(ex(0, 4'b0000, 0, 0, 4'b1111, 1, 0, 0, 0)));
    bus.DREQ = '0; bus.HLDA = 1'b0;
    tick();
    RESET_N = 1'b1;
    check("reset held", 32'(actual()), 32'(ex(0, 4'b0000, 0, 0, 4'b1111, 1, 0, 0, 0)));

    // Table-driven fixed-priority sequence.
    xferType = 8'b00_10_01_00;
    tick();
    for (int i = 0; i < 14; i++) begin
      bus.DREQ = vecs[i].dreq; bus.HLDA = vecs[i].hlda; tcReached = vecs[i].tc;
      tick();
      check($sformatf("fixed vec %0d", i), 32'(actual()), 32'(vecs[i].expv));
    end
    tcReached = 1'b0;

    // Rotating priority, all channels requesting, then ch2 masked.
    rotPriority = 1'b1; bus.DREQ = 4'b1111; bus.HLDA = 1'b1;
    doReset();
    collectGrants(5, 60);
    for (int i = 0; i < 5; i++)
      if (i < grantQ.size()) check($sformatf("rotate order %0d", i), 32'(grantQ[i]), 32'(expRot[i]));
    chMask = 4'b0100;
    doReset();
    collectGrants(4, 60);
    for (int i = 0; i < 4; i++)
      if (i < grantQ.size()) check($sformatf("masked order %0d", i), 32'(grantQ[i]), 32'(expMask[i]));
    chMask = '0;

    // Demand mode burst on ch0 ending on terminal count in the third transfer.
    rotPriority = 1'b0; demandMode = 4'b0001; xferType = 8'b00_00_00_01;
    bus.DREQ = 4'b0001; bus.HLDA = 1'b1;
    doReset();
    s1Cnt = 0; pulseCnt = 0; eopAt = -1; done = 0; hrqGap = 0; dackGap = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (bus.ADSTB) begin
        s1Cnt++;
        if (s1Cnt == 3) tcReached = 1'b1;
      end
      if (s1Cnt > 0 && !bus.HRQ) hrqGap = 1;
      if (s1Cnt > 0 && bus.DACK != 4'b0001) dackGap = 1;
      if (incrA) pulseCnt++;
      if (intEOP) begin
        eopAt = s1Cnt;
        done = 1;
      end
    end
    check("demand eop seen", 32'(done), 32'd1);
    check("demand eop transfer", 32'(eopAt), 32'd3);
    check("demand pulse count", 32'(pulseCnt), 32'd3);
    check("demand hrq continuous", 32'(hrqGap), 32'd0);
    check("demand dack continuous", 32'(dackGap), 32'd0);
    tick();
    check("demand back to idle", 32'(actual()), 32'(ex(0, 4'b0000, 0, 0, 4'b1111, 1, 0, 0, 0)));
    tcReached = 1'b0;

    // External EOP in S3 ends a demand burst.
    doReset();
    waitAdstb("eop S1");
    tick(); tick();
    bus.EOP_N = 1'b0;
    tick();
    bus.EOP_N = 1'b1;
    check("eop S4", 32'(actual()), 32'(ex(1, 4'b0001, 1, 0, 4'b1111, 0, 0, 1, 1)));
    tick();
    check("eop to idle", 32'(actual()), 32'(ex(0, 4'b0000, 0, 0, 4'b1111, 1, 0, 0, 0)));

    // HLDA loss in S2 aborts without pulses and leaves the pointer alone.
    demandMode = '0; rotPriority = 1'b1; bus.DREQ = 4'b0010; bus.HLDA = 1'b1;
    doReset();
    waitAdstb("abort S1");
    tick();
    bus.HLDA = 1'b0;
    tick();
    check("abort to idle", 32'(actual()), 32'(ex(0, 4'b0000, 0, 0, 4'b1111, 1, 0, 0, 0)));
    bus.DREQ = 4'b1111; bus.HLDA = 1'b1;
    collectGrants(1, 20);
    if (grantQ.size() > 0) check("abort pointer kept", 32'(grantQ[0]), 32'd0);

    // Controller disable blocks arbitration only.
    rotPriority = 1'b0; ctrlDisable = 1'b1; bus.DREQ = 4'b0001; bus.HLDA = 1'b0;
    doReset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("disabled idle %0d", i), 32'(actual()),
            32'(ex(0, 4'b0000, 0, 0, 4'b1111, 1, 0, 0, 0)));
    end
    ctrlDisable = 1'b0;
    tick();
    check("enabled S0", 32'(actual()), 32'(ex(1, 4'b0000, 0, 0, 4'b1111, 0, 0, 0, 0)));

    // Randomized traffic against the reference model.
    bus.DREQ = '0; bus.HLDA = 1'b0; demandMode = 4'b0101;
    doReset();
    mPhase = 0; mCh = 0; mPtr = 0; mEop = 0; mTerm = 0;
    pulseSeen = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 9) < 3) bus.DREQ = 4'($urandom) | 4'($urandom);
      bus.HLDA = ($urandom_range(0, 9) < 8);
      bus.EOP_N = ($urandom_range(0, 9) != 0);
      ctrlDisable = ($urandom_range(0, 19) == 0);
      chMask = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 49) == 0) rotPriority = ~rotPriority;
      if ($urandom_range(0, 99) == 0) demandMode = 4'($urandom);
      if (mPhase != 5) tcReached = ($urandom_range(0, 4) == 0);
      if (mPhase == 0 && $urandom_range(0, 9) == 0) xferType = 8'($urandom);
      @(posedge CLK);
      modelStep();
      @(negedge CLK);
      if (mPhase == 5) pulseSeen = 1;
      check($sformatf("random cyc %0d", cyc), 32'(actual()), 32'(modelOut()));
    end
    check("random reached S4", 32'(pulseSeen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
